// File: rtl/spmv_axil_ctrl_regs.sv
// AXI4-Lite register file for the SpMV kernels: config regs, start pulse, status, busy-cycle counter.
// Write response two cycles after AW+W; AW/W stall while their holding slot is full, AR stalls while rvalid is pending.
module spmv_axil_ctrl_regs #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int CONF_NUM_KERNEL = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              s_axil_awvalid,
    input  logic [ADDR_W-1:0] s_axil_awaddr,
    output logic              s_axil_awready,
    input  logic              s_axil_wvalid,
    input  logic [DATA_W-1:0] s_axil_wdata,
    output logic              s_axil_wready,
    output logic              s_axil_bvalid,
    output logic [1:0]        s_axil_bresp,
    input  logic              s_axil_bready,
    input  logic              s_axil_arvalid,
    input  logic [ADDR_W-1:0] s_axil_araddr,
    output logic              s_axil_arready,
    output logic              s_axil_rvalid,
    output logic [DATA_W-1:0] s_axil_rdata,
    output logic [1:0]        s_axil_rresp,
    input  logic              s_axil_rready,
    output logic              start_pulse,
    output logic [DATA_W-2:0] ctrl_mode,
    output logic [DATA_W-1:0] cfg_rows,
    output logic [DATA_W-1:0] cfg_cols,
    output logic [DATA_W-1:0] cfg_base,
    input  logic              kernel_busy,
    input  logic              kernel_done
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [5:0] IDX_CTRL   = 6'd0;
    localparam logic [5:0] IDX_ROWS   = 6'd1;
    localparam logic [5:0] IDX_COLS   = 6'd2;
    localparam logic [5:0] IDX_BASE   = 6'd3;
    localparam logic [5:0] IDX_STATUS = 6'd4;
    localparam logic [5:0] IDX_CYCLES = 6'd5;
    localparam logic [5:0] IDX_ID     = 6'd6;

    logic              aw_held_q, aw_held_d;
    logic [5:0]        waddr_q, waddr_d;
    logic              w_held_q, w_held_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [DATA_W-2:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] rows_q, rows_d;
    logic [DATA_W-1:0] cols_q, cols_d;
    logic [DATA_W-1:0] base_q, base_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] cycles_q, cycles_d;
    logic              start_q, start_d;

    logic              commit;
    logic              start;
    logic [DATA_W-1:0] rd_data;
    logic [1:0]        rd_resp;
    logic              unused_addr_bits;

    // Only the word offset in addr[7:2] is decoded.
    assign unused_addr_bits = ^{s_axil_awaddr[ADDR_W-1:8], s_axil_awaddr[1:0],
                                s_axil_araddr[ADDR_W-1:8], s_axil_araddr[1:0]};

    assign commit = aw_held_q & w_held_q & ~bvalid_q;
    assign start  = commit & (waddr_q == IDX_CTRL) & wdata_q[0];

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        case (s_axil_araddr[7:2])
            IDX_CTRL:   rd_data = {ctrl_q, 1'b0};
            IDX_ROWS:   rd_data = rows_q;
            IDX_COLS:   rd_data = cols_q;
            IDX_BASE:   rd_data = base_q;
            IDX_STATUS: rd_data = {{(DATA_W-2){1'b0}}, done_q, kernel_busy};
            IDX_CYCLES: rd_data = cycles_q;
            IDX_ID:     rd_data = DATA_W'(CONF_NUM_KERNEL);
            default:    rd_resp = RESP_SLVERR;
        endcase
    end

    always_comb begin
        aw_held_d = aw_held_q;
        waddr_d   = waddr_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        ctrl_d    = ctrl_q;
        rows_d    = rows_q;
        cols_d    = cols_q;
        base_d    = base_q;
        start_d   = start;

        if (s_axil_bvalid & s_axil_bready) begin
            bvalid_d = 1'b0;
        end
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = (waddr_q <= IDX_BASE) ? RESP_OKAY : RESP_SLVERR;
            case (waddr_q)
                IDX_CTRL: ctrl_d = wdata_q[DATA_W-1:1];
                IDX_ROWS: rows_d = wdata_q;
                IDX_COLS: cols_d = wdata_q;
                IDX_BASE: base_d = wdata_q;
                default:  ;
            endcase
        end
        // Holding slots are empty whenever a handshake is possible, so no clash with commit.
        if (s_axil_awvalid & ~aw_held_q) begin
            aw_held_d = 1'b1;
            waddr_d   = s_axil_awaddr[7:2];
        end
        if (s_axil_wvalid & ~w_held_q) begin
            w_held_d = 1'b1;
            wdata_d  = s_axil_wdata;
        end

        if (s_axil_rvalid & s_axil_rready) begin
            rvalid_d = 1'b0;
        end
        if (s_axil_arvalid & ~rvalid_q) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_data;
            rresp_d  = rd_resp;
        end

        // Start takes priority over a coincident done pulse or busy cycle.
        if (start) begin
            done_d   = 1'b0;
            cycles_d = '0;
        end else begin
            done_d   = done_q | kernel_done;
            cycles_d = (kernel_busy && cycles_q != {DATA_W{1'b1}}) ? cycles_q + DATA_W'(1) : cycles_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_held_q <= 1'b0;
            waddr_q   <= '0;
            w_held_q  <= 1'b0;
            wdata_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            ctrl_q    <= '0;
            rows_q    <= '0;
            cols_q    <= '0;
            base_q    <= '0;
            done_q    <= 1'b0;
            cycles_q  <= '0;
            start_q   <= 1'b0;
        end else begin
            aw_held_q <= aw_held_d;
            waddr_q   <= waddr_d;
            w_held_q  <= w_held_d;
            wdata_q   <= wdata_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            ctrl_q    <= ctrl_d;
            rows_q    <= rows_d;
            cols_q    <= cols_d;
            base_q    <= base_d;
            done_q    <= done_d;
            cycles_q  <= cycles_d;
            start_q   <= start_d;
        end
    end

    assign s_axil_awready = ~aw_held_q;
    assign s_axil_wready  = ~w_held_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_arready = ~rvalid_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = rresp_q;
    assign start_pulse    = start_q;
    assign ctrl_mode      = ctrl_q;
    assign cfg_rows       = rows_q;
    assign cfg_cols       = cols_q;
    assign cfg_base       = base_q;

endmodule

// File: tb/tb_spmv_axil_ctrl_regs.sv
// Bench for spmv_axil_ctrl_regs: vector table, hand-timed corner sequences, random traffic vs. register model.
module tb_spmv_axil_ctrl_regs;

    logic        clk = 1'b0;
    logic        rstn;
    logic        s_axil_awvalid = 1'b0;
    logic [31:0] s_axil_awaddr  = '0;
    logic        s_axil_awready;
    logic        s_axil_wvalid  = 1'b0;
    logic [31:0] s_axil_wdata   = '0;
    logic        s_axil_wready;
    logic        s_axil_bvalid;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bready  = 1'b1;
    logic        s_axil_arvalid = 1'b0;
    logic [31:0] s_axil_araddr  = '0;
    logic        s_axil_arready;
    logic        s_axil_rvalid;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        s_axil_rready  = 1'b1;
    logic        start_pulse;
    logic [30:0] ctrl_mode;
    logic [31:0] cfg_rows, cfg_cols, cfg_base;
    logic        kernel_busy = 1'b0;
    logic        kernel_done = 1'b0;

    spmv_axil_ctrl_regs #(.ADDR_W(32), .DATA_W(32), .CONF_NUM_KERNEL(4)) dut (
        .clk(clk), .rstn(rstn),
        .s_axil_awvalid(s_axil_awvalid), .s_axil_awaddr(s_axil_awaddr), .s_axil_awready(s_axil_awready),
        .s_axil_wvalid(s_axil_wvalid), .s_axil_wdata(s_axil_wdata), .s_axil_wready(s_axil_wready),
        .s_axil_bvalid(s_axil_bvalid), .s_axil_bresp(s_axil_bresp), .s_axil_bready(s_axil_bready),
        .s_axil_arvalid(s_axil_arvalid), .s_axil_araddr(s_axil_araddr), .s_axil_arready(s_axil_arready),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rready(s_axil_rready),
        .start_pulse(start_pulse), .ctrl_mode(ctrl_mode),
        .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_base(cfg_base),
        .kernel_busy(kernel_busy), .kernel_done(kernel_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int exp_start = 0;

    always @(negedge clk) if (start_pulse === 1'b1) start_cnt++;

    // Reference model: register contents as the host should see them.
    logic [30:0] m_ctrl = '0;
    logic [31:0] m_rows = '0, m_cols = '0, m_base = '0, m_cycles = '0;
    logic        m_done = 1'b0;

    function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data);
        case (addr & 32'hFC)
            32'h00: begin
                m_ctrl = data[31:1];
                if (data[0]) begin m_done = 1'b0; m_cycles = 0; exp_start++; end
                return 2'b00;
            end
            32'h04: begin m_rows = data; return 2'b00; end
            32'h08: begin m_cols = data; return 2'b00; end
            32'h0C: begin m_base = data; return 2'b00; end
            default: return 2'b10;
        endcase
    endfunction

    function automatic logic [33:0] model_read(input logic [31:0] addr);
        case (addr & 32'hFC)
            32'h00: return {2'b00, m_ctrl, 1'b0};
            32'h04: return {2'b00, m_rows};
            32'h08: return {2'b00, m_cols};
            32'h0C: return {2'b00, m_base};
            32'h10: return {2'b00, 30'd0, m_done, kernel_busy};
            32'h14: return {2'b00, m_cycles};
            32'h18: return {2'b00, 32'd4};
            default: return {2'b10, 32'd0};
        endcase
    endfunction

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    // order: 0 = AW and W together, 1 = AW first, 2 = W first. Called and returns on a negedge.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int order,
                            output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, hs_aw, hs_w;
        int g = 0;
        resp = 2'bxx;
        while (!(aw_done && w_done)) begin
            if (g++ > 50) begin timeout("write_addr_data"); break; end
            s_axil_awvalid = !aw_done && (order != 2 || w_done);
            s_axil_wvalid  = !w_done && (order != 1 || aw_done);
            s_axil_awaddr  = addr;
            s_axil_wdata   = data;
            hs_aw = s_axil_awvalid && s_axil_awready;
            hs_w  = s_axil_wvalid && s_axil_wready;
            @(negedge clk);
            aw_done |= hs_aw;
            w_done  |= hs_w;
        end
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        g = 0;
        while (!s_axil_bvalid && g < 50) begin @(negedge clk); g++; end
        if (!s_axil_bvalid) timeout("write_resp");
        else begin
            resp = s_axil_bresp;
            @(negedge clk);
        end
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [33:0] res);
        int g = 0;
        res = 'x;
        s_axil_arvalid = 1'b1;
        s_axil_araddr  = addr;
        while (!s_axil_arready && g < 50) begin @(negedge clk); g++; end
        @(negedge clk);
        s_axil_arvalid = 1'b0;
        g = 0;
        while (!s_axil_rvalid && g < 50) begin @(negedge clk); g++; end
        if (!s_axil_rvalid) timeout("read_data");
        else begin
            res = {s_axil_rresp, s_axil_rdata};
            @(negedge clk);
        end
    endtask

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          order;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl[17];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  resp;
        logic [33:0] rd;
        logic [31:0] old_cols;
        int          seen;

        tbl[0]  = '{1, 32'h004, 32'h10,       2, 2'b00, 32'h0};
        tbl[1]  = '{1, 32'h008, 32'hA000,     2, 2'b00, 32'h0};
        tbl[2]  = '{0, 32'h004, 32'h0,        0, 2'b00, 32'h10};
        tbl[3]  = '{0, 32'h008, 32'h0,        0, 2'b00, 32'hA000};
        tbl[4]  = '{1, 32'h010, 32'hFFFF,     0, 2'b10, 32'h0};
        tbl[5]  = '{1, 32'h040, 32'h1234,     1, 2'b10, 32'h0};
        tbl[6]  = '{0, 32'h040, 32'h0,        0, 2'b10, 32'h0};
        tbl[7]  = '{0, 32'h018, 32'h0,        0, 2'b00, 32'h4};
        tbl[8]  = '{0, 32'h00C, 32'h0,        0, 2'b00, 32'h55};
        tbl[9]  = '{1, 32'h014, 32'h9,        0, 2'b10, 32'h0};
        tbl[10] = '{0, 32'h014, 32'h0,        0, 2'b00, 32'h0};
        tbl[11] = '{0, 32'h010, 32'h0,        0, 2'b00, 32'h0};
        tbl[12] = '{0, 32'h104, 32'h0,        0, 2'b00, 32'h10};
        tbl[13] = '{1, 32'h1FC, 32'h1,        0, 2'b10, 32'h0};
        tbl[14] = '{0, 32'h000, 32'h0,        0, 2'b00, 32'h2A};
        tbl[15] = '{1, 32'h208, 32'hBEEF,     1, 2'b00, 32'h0};
        tbl[16] = '{0, 32'h008, 32'h0,        0, 2'b00, 32'hBEEF};

        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_readys", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);
        check("rst_valids", {s_axil_bvalid, s_axil_rvalid, start_pulse}, 3'b000);
        check("rst_cfg", {ctrl_mode, cfg_rows, cfg_cols, cfg_base} == '0, 1);
        rstn = 1'b1;
        @(negedge clk);

        // AW in one cycle, W the next; CTRL bit0 starts the kernel.
        do_write(32'h00, 32'h2B, 1, resp);
        check("t1_bresp", resp, model_write(32'h00, 32'h2B));
        check("t1_bvalid_one_cycle", s_axil_bvalid, 0);
        check("t1_start_cnt", start_cnt, exp_start);
        check("t1_ctrl_mode", ctrl_mode, 31'h15);
        do_read(32'h00, rd);
        check("t1_read_ctrl", rd, {2'b00, 32'h2A});

        // AW+W together: bvalid two cycles later.
        s_axil_awvalid = 1'b1; s_axil_awaddr = 32'h0C;
        s_axil_wvalid  = 1'b1; s_axil_wdata  = 32'h55;
        @(negedge clk);
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        check("lat_bvalid_cycle1", s_axil_bvalid, 0);
        @(negedge clk);
        check("lat_bvalid_cycle2", {s_axil_bvalid, s_axil_bresp}, {1'b1, model_write(32'h0C, 32'h55)});
        @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            if (tbl[i].is_wr) begin
                do_write(tbl[i].addr, tbl[i].data, tbl[i].order, resp);
                void'(model_write(tbl[i].addr, tbl[i].data));
                check($sformatf("tbl%0d_bresp", i), resp, tbl[i].exp_resp);
            end else begin
                do_read(tbl[i].addr, rd);
                check($sformatf("tbl%0d_read", i), rd, {tbl[i].exp_resp, tbl[i].exp_rdata});
            end
        end
        check("tbl_cfg_ports", {cfg_rows, cfg_cols, cfg_base}, {32'h10, 32'hBEEF, 32'h55});
        check("tbl_start_cnt", start_cnt, exp_start);

        // 100 busy cycles then a done pulse.
        kernel_busy = 1'b1;
        repeat (100) @(negedge clk);
        kernel_busy = 1'b0;
        kernel_done = 1'b1;
        @(negedge clk);
        kernel_done = 1'b0;
        m_cycles = 100; m_done = 1'b1;
        do_read(32'h14, rd);
        check("busy_cycles", rd, {2'b00, 32'd100});
        do_read(32'h10, rd);
        check("busy_status", rd, {2'b00, 32'h2});

        // Start committed on the same edge as a done pulse and a busy cycle: start wins.
        s_axil_awvalid = 1'b1; s_axil_awaddr = 32'h00;
        s_axil_wvalid  = 1'b1; s_axil_wdata  = 32'h1;
        @(negedge clk);
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        kernel_done = 1'b1; kernel_busy = 1'b1;
        @(negedge clk);
        kernel_done = 1'b0; kernel_busy = 1'b0;
        check("sw_start_pulse", start_pulse, 1);
        check("sw_bresp", {s_axil_bvalid, s_axil_bresp}, {1'b1, model_write(32'h00, 32'h1)});
        @(negedge clk);
        do_read(32'h10, rd);
        check("sw_status_cleared", rd, {2'b00, 32'h0});
        do_read(32'h14, rd);
        check("sw_cycles_cleared", rd, {2'b00, 32'h0});

        // bready held low while a second write arrives.
        old_cols = cfg_cols;
        s_axil_bready = 1'b0;
        s_axil_awvalid = 1'b1; s_axil_awaddr = 32'h40;
        s_axil_wvalid  = 1'b1; s_axil_wdata  = 32'h99;
        @(negedge clk);
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        @(negedge clk);
        check("bq_first_resp", {s_axil_bvalid, s_axil_bresp}, {1'b1, model_write(32'h40, 32'h99)});
        s_axil_awvalid = 1'b1; s_axil_awaddr = 32'h08;
        s_axil_wvalid  = 1'b1; s_axil_wdata  = 32'h222;
        @(negedge clk);
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        check("bq_second_held", {s_axil_awready, s_axil_wready}, 2'b00);
        repeat (3) @(negedge clk);
        check("bq_not_committed", {s_axil_bvalid, s_axil_bresp, cfg_cols}, {1'b1, 2'b10, old_cols});
        s_axil_bready = 1'b1;
        @(negedge clk);
        check("bq_gap", s_axil_bvalid, 0);
        @(negedge clk);
        check("bq_second_resp", {s_axil_bvalid, s_axil_bresp}, {1'b1, model_write(32'h08, 32'h222)});
        check("bq_cols", cfg_cols, 32'h222);
        @(negedge clk);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] a, d;
            int off;
            off = $urandom_range(0, 15);
            a = ($urandom() & 32'hFFFFFF00) | (off << 2);
            d = $urandom();
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, d, $urandom_range(0, 2), resp);
                check("rnd_bresp", resp, model_write(a, d));
                check("rnd_ports", {ctrl_mode, cfg_rows, cfg_cols, cfg_base} == {m_ctrl, m_rows, m_cols, m_base}, 1);
            end else begin
                do_read(a, rd);
                check("rnd_read", rd, model_read(a));
            end
        end
        check("rnd_start_cnt", start_cnt, exp_start);

        // Reset with AW held and a read response pending.
        s_axil_rready = 1'b0;
        s_axil_awvalid = 1'b1; s_axil_awaddr = 32'h04;
        @(negedge clk);
        s_axil_awvalid = 1'b0;
        s_axil_arvalid = 1'b1; s_axil_araddr = 32'h18;
        @(negedge clk);
        s_axil_arvalid = 1'b0;
        check("mr_pending", {s_axil_awready, s_axil_rvalid}, 2'b01);
        rstn = 1'b0;
        #1;
        check("mr_readys", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);
        check("mr_outputs", {s_axil_bvalid, s_axil_rvalid, s_axil_rdata, cfg_rows, start_pulse}, '0);
        @(negedge clk);
        rstn = 1'b1;
        s_axil_rready = 1'b1;
        s_axil_wvalid = 1'b1; s_axil_wdata = 32'h77;
        @(negedge clk);
        s_axil_wvalid = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (s_axil_bvalid || s_axil_rvalid) seen++;
        end
        check("mr_no_stale_resp", seen, 0);
        check("mr_rows_zero", cfg_rows, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
